// File: rtl/ifetch_queue.sv
// Instruction-fetch sequencer: owns the fetch PC, reads one word per cycle from a
// combinational instruction memory, buffers {pc, instr, oob} entries and hands them
// to decode over valid/ready. A redirect flushes the queue and restarts fetch.
module ifetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_oob,
    output logic        redirect_misaligned
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        oob;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [31:0]        fetch_pc;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic               fetch_oob;
    entry_t             head_entry;

    // Handshake decode and head-entry presentation; nothing depends on out_ready but pop.
    always_comb begin
        imem_addr  = fetch_pc;
        fetch_oob  = ({2'b00, fetch_pc[31:2]} >= IMEM_WORDS);
        out_valid  = (count != '0);
        pop        = out_valid & out_ready;
        push       = fetch_en & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);
        head_entry = mem[head];
        out_instr  = NOP;
        out_pc     = 32'h0;
        out_oob    = 1'b0;
        if (out_valid) begin
            out_instr = head_entry.instr;
            out_pc    = head_entry.pc;
            out_oob   = head_entry.oob;
        end
    end

    // Entry storage; contents only matter below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: fetch_pc, instr: imem_instr, oob: fetch_oob};
        end
    end

    // Fetch PC, pointers and occupancy; a redirect overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc            <= RESET_PC;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            redirect_misaligned <= 1'b0;
        end else begin
            redirect_misaligned <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    tail     <= tail + PTR_W'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction-fetch sequencer that drives the address of the combinational instruction memory and owns the fetch PC. It issues one word read per cycle and buffers {pc, instruction} pairs in a small FIFO, then hands them to decode over a valid/ready handshake. It also handles control-flow redirects by flushing the queue and restarting fetch at the new PC.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2.
RESET_PC, 32'h00000000, fetch PC loaded on reset.
IMEM_WORDS, 16384, instruction memory size in 32-bit words; used for the out-of-range flag.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
fetch_en  input  1  when 1, fetch is allowed; when 0, no new pushes occur and the queue drains.
imem_addr  output  32  byte address to instruction memory; equals fetch_pc combinationally.
imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
redirect_valid  input  1  branch, jump or trap redirect request.
redirect_pc  input  32  target PC for the redirect.
out_valid  output  1  head entry is valid.
out_ready  input  1  decode accepts the head entry.
out_instr  output  32  head instruction; 32'h00000013 (NOP) when empty.
out_pc  output  32  PC of the head entry; 0 when empty.
out_oob  output  1  head entry was fetched from an address with pc[31:2] >= IMEM_WORDS.
redirect_misaligned  output  1  registered; set for one cycle after a redirect whose redirect_pc[1:0] != 0.

Behaviour:
- State: fetch_pc (32 bits), FIFO storage of DEPTH x {pc[31:0], instr[31:0], oob}, head and tail pointers, and count (0..DEPTH).
- Reset (rst_n=0, asynchronous): fetch_pc=RESET_PC, count=0, pointers=0, redirect_misaligned=0.
  - Outputs during reset: out_valid=0, out_instr=32'h00000013, out_pc=0, out_oob=0, imem_addr=RESET_PC.
- Outputs are driven from the head entry, with no combinational path from out_ready.
  - out_valid = (count != 0).
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
  - A full queue with a simultaneous pop therefore pushes in the same cycle.
- On push: write {fetch_pc, imem_instr, fetch_pc[31:2] >= IMEM_WORDS} at the tail, advance the tail, and set fetch_pc = fetch_pc + 4.
  - The addition is modulo 2^32: 32'hFFFFFFFC wraps to 0.
- count update: count += push - pop. Pointers wrap modulo DEPTH.
- Redirect has priority over everything else in that cycle:
  - count=0, head=tail=0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No push occurs that cycle.
  - A pop handshaken in the same cycle is treated as consumed by decode, but the queue is flushed regardless.
  - redirect_misaligned <= |redirect_pc[1:0] on the redirect edge; otherwise it is cleared the next cycle.
- Latency:
  - First out_valid=1 one cycle after reset release, given fetch_en=1.
  - Redirect to first valid target entry: 2 edges (flush edge, then push edge).
  - Steady-state throughput: 1 instruction per cycle with out_ready held at 1.
- With fetch_en=0: fetch_pc holds, the queue drains through pops, and out_valid falls once count reaches 0. Redirects are still accepted.
- Out-of-range addresses are still fetched; imem returns NOP for them, and out_oob flags the entry.
- Reset asserted mid-operation discards all entries immediately; there is no partial state.

Test Plan:
1. Reset release with fetch_en=1, out_ready=1, imem returning the word address as data -> out_pc 0,4,8,12 on consecutive cycles with out_instr 0,1,2,3, and out_valid=1 from cycle 1.
2. out_ready=0 for 10 cycles -> count saturates at 4 and imem_addr holds at 16; raising out_ready then streams pc 0,4,8,12,16 with no gap and no duplicate.
3. Full queue with redirect_valid=1, redirect_pc=32'h00000100, out_ready=1 on the same cycle -> next cycle out_valid=0; the cycle after, out_pc=32'h100; no stale entries appear.
4. redirect_pc=32'h00000103 -> fetch resumes at 32'h100 and redirect_misaligned=1 for exactly one cycle.
5. Redirect to 32'h0000FFFC with IMEM_WORDS=16384 -> 32'hFFFC has out_oob=0; the next entry, pc 32'h10000, has out_oob=1 and out_instr=32'h00000013. Separately, a redirect to 32'hFFFFFFFC fetches next at pc 0.
6. Assert rst_n low mid-stream with count=3 -> out_valid drops to 0 asynchronously before the next edge; after release, fetch restarts at RESET_PC.
